// File: rtl/uart_frame_core_pkg.sv
// Shared definitions for the framed UART layer.
//  - rx_state_t / tx_state_t : state types for the RX parser and the TX sequencer
//  - DEFAULT_SYNC_BYTE       : frame start marker used in both directions
//  - xor_acc()               : running XOR checksum step
package uart_frame_core_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_CHECK
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_GAP,
    T_WAIT
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_core_tx.sv
// TX framer: takes one RESULT_BYTES word by valid/ready and feeds a byte UART
// with SYNC_BYTE, the word MSB byte first, then the XOR of the word bytes.
// Ports:
//  clock, reset         system clock, synchronous active-low reset
//  result_data/valid    word offered for transmission
//  result_ready         high only while idle (and not in reset)
//  tx_data, tx_wr_en    byte and one-cycle load strobe towards the UART
//  tx_busy              UART transmitter busy
module uart_frame_tx
  import uart_frame_core_pkg::*;
#(
  parameter int unsigned RESULT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RESULT_BYTES*8-1:0] result_data,
  input  logic                    result_valid,
  output logic                    result_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_wr_en,
  input  logic                    tx_busy
);

  localparam int unsigned RW = RESULT_BYTES * 8;
  localparam int unsigned IW = $clog2(RESULT_BYTES + 3);

  tx_state_t      r_state;
  tx_state_t      w_next;
  logic [RW-1:0]  r_word;
  logic [7:0]     r_xor;
  logic [IW-1:0]  r_idx;
  logic           r_ready;
  logic [7:0]     r_tx_data;
  logic           r_wr_en;
  logic [7:0]     w_byte;
  logic           w_accept;
  logic           w_send;
  logic           w_is_data;

  assign result_ready = r_ready;
  assign tx_data      = r_tx_data;
  assign tx_wr_en     = r_wr_en;

  // Index 0 is the sync byte, 1..RESULT_BYTES the word (always taken from the
  // top of the shifting word register), RESULT_BYTES+1 the checksum.
  assign w_is_data = (r_idx != '0) && (r_idx <= IW'(RESULT_BYTES));

  always_comb begin
    w_byte = r_xor;
    if (r_idx == '0) begin
      w_byte = SYNC_BYTE;
    end else if (w_is_data) begin
      w_byte = r_word[RW-1 -: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= T_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_send   = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (result_valid && r_ready) begin
          w_accept = 1'b1;
          w_next   = T_LOAD;
        end
      end
      T_LOAD: begin
        if (!tx_busy) begin
          w_send = 1'b1;
          w_next = T_GAP;
        end
      end
      // UART raises busy a cycle after the strobe; skip that cycle.
      T_GAP: w_next = T_WAIT;
      T_WAIT: begin
        if (!tx_busy) begin
          w_next = (r_idx == IW'(RESULT_BYTES + 2)) ? T_IDLE : T_LOAD;
        end
      end
      default: w_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ready   <= 1'b0;
      r_tx_data <= '0;
      r_wr_en   <= 1'b0;
      r_word    <= '0;
      r_xor     <= '0;
      r_idx     <= '0;
    end else begin
      // Registered so ready stays low while reset is held and rises the cycle after.
      r_ready <= (w_next == T_IDLE);
      r_wr_en <= w_send;
      if (w_accept) begin
        r_word <= result_data;
        r_xor  <= '0;
        r_idx  <= '0;
      end
      if (w_send) begin
        r_tx_data <= w_byte;
        r_idx     <= r_idx + 1'b1;
        if (w_is_data) begin
          r_xor  <= xor_acc(r_xor, w_byte);
          r_word <= r_word << 8;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_core.sv
// Framed protocol layer between a byte UART and the miner datapath.
// RX: hunts SYNC_BYTE, collects HEADER_BYTES payload bytes, checks the XOR
// checksum byte, aborts stalled frames, publishes the header atomically.
// TX: delegated to uart_frame_tx. RX and TX are independent.
// Ports:
//  clock, reset               system clock, synchronous active-low reset
//  rx_data, rx_valid          received byte + one-cycle valid pulse
//  tx_data, tx_wr_en, tx_busy byte UART transmit interface
//  header_data, header_valid  last good header (first byte in MSBs) + update pulse
//  frame_error                pulse on checksum mismatch or inter-byte timeout
//  result_data/valid/ready    word to transmit, valid/ready handshake
module uart_frame_core
  import uart_frame_core_pkg::*;
#(
  parameter int unsigned HEADER_BYTES   = 80,
  parameter int unsigned RESULT_BYTES   = 4,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [7:0]                tx_data,
  output logic                      tx_wr_en,
  input  logic                      tx_busy,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      frame_error,
  input  logic [RESULT_BYTES*8-1:0] result_data,
  input  logic                      result_valid,
  output logic                      result_ready
);

  localparam int unsigned HW = HEADER_BYTES * 8;
  localparam int unsigned CW = $clog2(HEADER_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  rx_state_t      r_rx_state;
  rx_state_t      w_rx_next;
  logic [HW-1:0]  r_stage;
  logic [HW-1:0]  r_header;
  logic [7:0]     r_xor;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_to;
  logic           r_hdr_valid;
  logic           r_frame_err;
  logic           w_timeout;
  logic           w_hdr_load;
  logic           w_err;

  assign header_data  = r_header;
  assign header_valid = r_hdr_valid;
  assign frame_error  = r_frame_err;

  // A byte arriving on the expiry cycle keeps the frame alive.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_rx_state != R_IDLE) && !rx_valid &&
                     (r_to >= TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_state <= R_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next  = r_rx_state;
    w_hdr_load = 1'b0;
    w_err      = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) w_rx_next = R_DATA;
      end
      R_DATA: begin
        if (rx_valid) begin
          if (r_cnt == CW'(HEADER_BYTES - 1)) w_rx_next = R_CHECK;
        end else if (w_timeout) begin
          w_err     = 1'b1;
          w_rx_next = R_IDLE;
        end
      end
      R_CHECK: begin
        if (rx_valid) begin
          w_rx_next = R_IDLE;
          if (rx_data == r_xor) w_hdr_load = 1'b1;
          else                  w_err      = 1'b1;
        end else if (w_timeout) begin
          w_err     = 1'b1;
          w_rx_next = R_IDLE;
        end
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stage     <= '0;
      r_header    <= '0;
      r_xor       <= '0;
      r_cnt       <= '0;
      r_to        <= '0;
      r_hdr_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_hdr_valid <= w_hdr_load;
      r_frame_err <= w_err;
      if (w_hdr_load) r_header <= r_stage;

      if ((r_rx_state == R_IDLE) || rx_valid) begin
        r_to <= '0;
      end else if (r_to != TW'(TIMEOUT_CYCLES)) begin
        r_to <= r_to + 1'b1;
      end

      case (r_rx_state)
        R_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            r_cnt <= '0;
            r_xor <= '0;
          end
        end
        R_DATA: begin
          if (rx_valid) begin
            r_stage <= (r_stage << 8) | HW'(rx_data);
            r_xor   <= xor_acc(r_xor, rx_data);
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_frame_tx #(
    .RESULT_BYTES (RESULT_BYTES),
    .SYNC_BYTE    (SYNC_BYTE)
  ) u_tx (
    .clock        (clock),
    .reset        (reset),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .tx_data      (tx_data),
    .tx_wr_en     (tx_wr_en),
    .tx_busy      (tx_busy)
  );

endmodule

// File: tb/tb_uart_frame_core.sv
module tb_uart_frame_core;

  localparam int unsigned HB = 4;
  localparam int unsigned RB = 4;
  localparam int unsigned TO = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic          tx_busy;
  logic [HB*8-1:0] header_data;
  logic          header_valid;
  logic          frame_error;
  logic [RB*8-1:0] result_data = '0;
  logic          result_valid = 1'b0;
  logic          result_ready;

  uart_frame_core #(
    .HEADER_BYTES   (HB),
    .RESULT_BYTES   (RB),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_wr_en     (tx_wr_en),
    .tx_busy      (tx_busy),
    .header_data  (header_data),
    .header_valid (header_valid),
    .frame_error  (frame_error),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  // Byte UART model: busy for 10 clocks after each load strobe.
  int busy_cnt = 0;
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clock) begin
    if (tx_wr_en === 1'b1) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Output monitor
  logic [7:0]  obs_tx[$];
  logic [31:0] obs_hdr[$];
  int n_wr = 0;
  int n_err = 0;
  int wr_double = 0;
  logic prev_wr = 1'b0;
  always @(negedge clock) begin
    if (tx_wr_en === 1'b1) begin
      obs_tx.push_back(tx_data);
      n_wr++;
      if (prev_wr) wr_double++;
    end
    prev_wr = (tx_wr_en === 1'b1);
    if (header_valid === 1'b1) obs_hdr.push_back(header_data);
    if (frame_error === 1'b1) n_err++;
  end

  // Scoreboards
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_hdr[$];
  int exp_err = 0;
  logic [31:0] last_hdr = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic rx_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic rx_frame(input logic [31:0] w, input logic [7:0] ck);
    rx_byte(8'hA5, 1);
    for (int i = 3; i >= 0; i--) rx_byte(w[i*8 +: 8], 1);
    rx_byte(ck, 1);
  endtask

  task automatic hdr_check(input string tag);
    logic [31:0] e;
    logic [31:0] o;
    chk({tag, "_count"}, obs_hdr.size(), exp_hdr.size());
    while (exp_hdr.size() > 0) begin
      e = exp_hdr.pop_front();
      o = (obs_hdr.size() > 0) ? obs_hdr.pop_front() : 32'hxxxxxxxx;
      chk({tag, "_data"}, o, e);
    end
    obs_hdr.delete();
    chk({tag, "_err"}, n_err, exp_err);
  endtask

  task automatic tx_check(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    int idx = 0;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      o = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, idx), o, e);
      idx++;
    end
    chk({tag, "_extra"}, obs_tx.size(), 0);
    obs_tx.delete();
  endtask

  task automatic tx_push(input logic [31:0] w);
    exp_tx.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
    exp_tx.push_back(xor4(w));
  endtask

  initial begin
    int base;
    int k_hit;
    int hdr_before;

    // Reset
    tick(3);
    chk("rst_ready", result_ready, 0);
    chk("rst_wr_en", tx_wr_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_header", header_data, 0);
    chk("rst_hvalid", header_valid, 0);
    chk("rst_ferr", frame_error, 0);
    reset = 1'b1;
    tick(1);
    chk("ready_after_rst", result_ready, 1);

    // Good frame
    exp_hdr.push_back(32'h11223344);
    last_hdr = 32'h11223344;
    rx_frame(32'h11223344, xor4(32'h11223344));
    hdr_check("rx_good");

    // Bad checksum: error, header unchanged
    rx_frame(32'h11223344, xor4(32'h11223344) ^ 8'h01);
    exp_err++;
    hdr_check("rx_badck");
    chk("rx_badck_hold", header_data, last_hdr);

    // Junk before sync, sync value inside payload
    rx_byte(8'h00, 1);
    rx_byte(8'hFF, 1);
    exp_hdr.push_back(32'hA5010203);
    last_hdr = 32'hA5010203;
    rx_frame(32'hA5010203, xor4(32'hA5010203));
    hdr_check("rx_junk");

    // Timeout after a stalled frame
    rx_byte(8'hA5, 1);
    rx_byte(8'h11, 0);
    k_hit = -1;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      if (frame_error === 1'b1 && k_hit < 0) k_hit = k;
    end
    chk("rx_timeout_cycle", k_hit, TO);
    exp_err++;
    chk("rx_timeout_hold", header_data, last_hdr);
    exp_hdr.push_back(32'h5A5B5C5D);
    last_hdr = 32'h5A5B5C5D;
    rx_frame(32'h5A5B5C5D, xor4(32'h5A5B5C5D));
    hdr_check("rx_after_to");

    // Byte arriving exactly on the expiry cycle keeps the frame alive
    rx_byte(8'hA5, 1);
    rx_byte(8'h11, TO - 1);
    rx_byte(8'h22, 1);
    rx_byte(8'h33, 1);
    rx_byte(8'h44, 1);
    exp_hdr.push_back(32'h11223344);
    last_hdr = 32'h11223344;
    rx_byte(xor4(32'h11223344), 1);
    hdr_check("rx_edge_to");

    // TX frame
    chk("tx_ready_idle", result_ready, 1);
    base = n_wr;
    tx_push(32'hDEADBEEF);
    result_data  = 32'hDEADBEEF;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    result_data  = 32'h0BADF00D;
    chk("tx_ready_low", result_ready, 0);
    for (int i = 0; i < 300 && result_ready !== 1'b1; i++) begin
      if (i == 20) result_valid = 1'b1;
      tick(1);
    end
    result_valid = 1'b0;
    chk("tx_done", result_ready, 1);
    chk("tx_ready_after_all", n_wr - base, 6);
    tx_check("tx_deadbeef");
    chk("tx_wr_single", wr_double, 0);

    // Reset in the middle of TX and RX
    tick(3);
    base = n_wr;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h01);
    result_data  = 32'h01020304;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    rx_byte(8'hA5, 1);
    rx_byte(8'h11, 1);
    rx_byte(8'h22, 1);
    for (int i = 0; i < 100 && n_wr < base + 2; i++) tick(1);
    chk("mid_two_bytes", n_wr - base, 2);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_ready", result_ready, 0);
    chk("mid_rst_wr_en", tx_wr_en, 0);
    chk("mid_rst_header", header_data, 0);
    reset = 1'b1;
    tick(1);
    chk("mid_ready_after", result_ready, 1);
    tick(40);
    chk("mid_no_more_wr", n_wr - base, 2);
    tx_check("tx_mid");
    hdr_before = obs_hdr.size();
    rx_byte(8'h33, 1);
    rx_byte(8'h44, 1);
    rx_byte(xor4(32'h11223344), 1);
    tick(3);
    chk("mid_rx_discard", obs_hdr.size(), hdr_before);
    chk("mid_rx_noerr", n_err, exp_err);
    chk("mid_header_zero", header_data, 0);
    exp_hdr.push_back(32'hCAFEF00D);
    rx_frame(32'hCAFEF00D, xor4(32'hCAFEF00D));
    hdr_check("rx_final");
    chk("final_wr_single", wr_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
